// File: rtl/chunked_adder_if.sv
// chunked_adder_if: operand/result handshake bundle for chunked_adder.
// The master side (producer/consumer) drives operands and out_rdy; the
// slave side (the adder) drives in_rdy and the result.
// Optional: CHUNKED_ADDER_OVERFLOW_EN adds the signed-overflow flag out_ovf.
interface chunked_adder_if #(
    parameter int NBITS = 32
);
    logic             in_val;
    logic             in_rdy;
    logic [NBITS-1:0] in_a;
    logic [NBITS-1:0] in_b;
    logic             in_cin;
    logic             out_val;
    logic             out_rdy;
    logic [NBITS-1:0] out_sum;
    logic             out_cout;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
    logic             out_ovf;

    modport master (
        output in_val, in_a, in_b, in_cin, out_rdy,
        input  in_rdy, out_val, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_val, in_a, in_b, in_cin, out_rdy,
        output in_rdy, out_val, out_sum, out_cout, out_ovf
    );
`else
    modport master (
        output in_val, in_a, in_b, in_cin, out_rdy,
        input  in_rdy, out_val, out_sum, out_cout
    );

    modport slave (
        input  in_val, in_a, in_b, in_cin, out_rdy,
        output in_rdy, out_val, out_sum, out_cout
    );
`endif
endinterface

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle ripple adder that adds CBITS bits per clock.
// Operands are latched on acceptance, then NCHUNKS CALC cycles walk the
// chunks from LSB to MSB carrying between them; the result is presented in
// DONE until the consumer pops it. NBITS must be a multiple of CBITS.
// Optional: define CHUNKED_ADDER_OVERFLOW_EN to add out_ovf, the two's-
// complement overflow flag (carry into MSB xor carry out of MSB).
module chunked_adder #(
    parameter int NBITS = 32,
    parameter int CBITS = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    chunked_adder_if.slave bus
);

    localparam int NCHUNKS = NBITS / CBITS;
    localparam int IDXW    = (NCHUNKS > 1) ? $clog2(NCHUNKS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [NBITS-1:0] a_reg;
    logic [NBITS-1:0] b_reg;
    logic [NBITS-1:0] work_reg;      // partial sum being built during CALC
    logic [NBITS-1:0] out_sum_reg;   // last complete result, stable between results
    logic             carry_reg;
    logic             out_cout_reg;
    logic             out_val_reg;
    logic             in_rdy_reg;
    logic [IDXW-1:0]  idx_reg;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
    logic             out_ovf_reg;
    logic             msb_cin;
`endif

    // Chunk views of the latched operands.
    logic [CBITS-1:0] a_chunk [NCHUNKS];
    logic [CBITS-1:0] b_chunk [NCHUNKS];

    logic [CBITS-1:0] a_sel;
    logic [CBITS-1:0] b_sel;
    logic [CBITS:0]   chunk_total;
    logic [CBITS-1:0] chunk_s;
    logic             chunk_c;
    logic [NBITS-1:0] merged_sum;    // work_reg with the current chunk replaced

    genvar gi;
    generate
        for (gi = 0; gi < NCHUNKS; gi++) begin : g_chunk
            assign a_chunk[gi] = a_reg[gi*CBITS +: CBITS];
            assign b_chunk[gi] = b_reg[gi*CBITS +: CBITS];
            assign merged_sum[gi*CBITS +: CBITS] =
                (idx_reg == IDXW'(gi)) ? chunk_s : work_reg[gi*CBITS +: CBITS];
        end
    endgenerate

    // Select the operand chunk addressed by the chunk index.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NCHUNKS; i++) begin
            if (idx_reg == IDXW'(i)) begin
                a_sel = a_chunk[i];
                b_sel = b_chunk[i];
            end
        end
    end

    assign chunk_total = {1'b0, a_sel} + {1'b0, b_sel} + (CBITS+1)'(carry_reg);
    assign chunk_s     = chunk_total[CBITS-1:0];
    assign chunk_c     = chunk_total[CBITS];

`ifdef CHUNKED_ADDER_OVERFLOW_EN
    // Carry into the top bit of the chunk, recovered from its sum bit; only
    // meaningful on the last chunk where this is the MSB of the word.
    assign msb_cin = a_sel[CBITS-1] ^ b_sel[CBITS-1] ^ chunk_s[CBITS-1];
`endif

    // Control FSM and datapath registers; all outputs are registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            work_reg     <= '0;
            out_sum_reg  <= '0;
            carry_reg    <= 1'b0;
            out_cout_reg <= 1'b0;
            out_val_reg  <= 1'b0;
            in_rdy_reg   <= 1'b1;
            idx_reg      <= '0;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
            out_ovf_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_val) begin
                        a_reg      <= bus.in_a;
                        b_reg      <= bus.in_b;
                        carry_reg  <= bus.in_cin;
                        idx_reg    <= '0;
                        in_rdy_reg <= 1'b0;
                        state_reg  <= CALC;
                    end
                end
                CALC: begin
                    work_reg  <= merged_sum;
                    carry_reg <= chunk_c;
                    if (idx_reg == LAST_IDX) begin
                        out_sum_reg  <= merged_sum;
                        out_cout_reg <= chunk_c;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
                        out_ovf_reg  <= msb_cin ^ chunk_c;
`endif
                        out_val_reg  <= 1'b1;
                        idx_reg      <= '0;
                        state_reg    <= DONE;
                    end else begin
                        idx_reg <= idx_reg + IDXW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_rdy) begin
                        out_val_reg <= 1'b0;
                        in_rdy_reg  <= 1'b1;
                        state_reg   <= IDLE;
                    end
                end
                default: begin
                    out_val_reg <= 1'b0;
                    in_rdy_reg  <= 1'b1;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_rdy   = in_rdy_reg;
    assign bus.out_val  = out_val_reg;
    assign bus.out_sum  = out_sum_reg;
    assign bus.out_cout = out_cout_reg;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
    assign bus.out_ovf  = out_ovf_reg;
`endif

endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: directed checks on an 8-bit/4-bit instance plus
// back-to-back random traffic on 32-bit instances with CBITS = 1, 4, 32.
// Overflow checks are compiled in when CHUNKED_ADDER_OVERFLOW_EN is defined.
module tb_chunked_adder;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- 8-bit directed instance ----------------
    chunked_adder_if #(.NBITS(8)) s_if ();

    chunked_adder #(.NBITS(8), .CBITS(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (s_if.slave)
    );

    // ---------------- 32-bit random instances ----------------
    logic [2:0]        rv_in_val;
    logic [2:0][31:0]  rv_in_a;
    logic [2:0][31:0]  rv_in_b;
    logic [2:0]        rv_in_cin;
    logic [2:0]        rv_out_rdy;
    logic [2:0]        rv_in_rdy;
    logic [2:0]        rv_out_val;
    logic [2:0][31:0]  rv_out_sum;
    logic [2:0]        rv_out_cout;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rnd
            localparam int CB = (gi == 0) ? 1 : ((gi == 1) ? 4 : 32);
            chunked_adder_if #(.NBITS(32)) r_if ();
            assign r_if.in_val      = rv_in_val[gi];
            assign r_if.in_a        = rv_in_a[gi];
            assign r_if.in_b        = rv_in_b[gi];
            assign r_if.in_cin      = rv_in_cin[gi];
            assign r_if.out_rdy     = rv_out_rdy[gi];
            assign rv_in_rdy[gi]    = r_if.in_rdy;
            assign rv_out_val[gi]   = r_if.out_val;
            assign rv_out_sum[gi]   = r_if.out_sum;
            assign rv_out_cout[gi]  = r_if.out_cout;
            chunked_adder #(.NBITS(32), .CBITS(CB)) u_dut (
                .clk     (clk),
                .reset_n (reset_n),
                .bus     (r_if.slave)
            );
        end
    endgenerate

    // Present operands at a negedge; returns one negedge after the accepting edge.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        s_if.in_val = 1'b1;
        s_if.in_a   = a;
        s_if.in_b   = b;
        s_if.in_cin = cin;
        @(negedge clk);
        s_if.in_val = 1'b0;
    endtask

    // Count cycles after acceptance until out_val, bounded.
    task automatic wait_val8(output int lat);
        lat = 0;
        while (s_if.out_val !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop8();
        s_if.out_rdy = 1'b1;
        @(negedge clk);
        s_if.out_rdy = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (s_if.in_rdy !== 1'b1) begin errors++; $display("FAIL rst_in_rdy got=%b exp=1", s_if.in_rdy); end
        checks++; if (s_if.out_val !== 1'b0) begin errors++; $display("FAIL rst_out_val got=%b exp=0", s_if.out_val); end
        checks++; if (s_if.out_sum !== 8'h00) begin errors++; $display("FAIL rst_out_sum got=%h exp=00", s_if.out_sum); end
        checks++; if (s_if.out_cout !== 1'b0) begin errors++; $display("FAIL rst_out_cout got=%b exp=0", s_if.out_cout); end
`ifdef CHUNKED_ADDER_OVERFLOW_EN
        checks++; if (s_if.out_ovf !== 1'b0) begin errors++; $display("FAIL rst_out_ovf got=%b exp=0", s_if.out_ovf); end
`endif
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (s_if.in_rdy !== 1'b1) begin errors++; $display("FAIL rel_in_rdy got=%b exp=1", s_if.in_rdy); end
        checks++; if (s_if.out_val !== 1'b0) begin errors++; $display("FAIL rel_out_val got=%b exp=0", s_if.out_val); end
        $display("reset: in_rdy=%b out_val=%b", s_if.in_rdy, s_if.out_val);
    endtask

    task automatic test_carry_chain();
        int lat;
        issue8(8'hFF, 8'h01, 1'b0);
        wait_val8(lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL cc_latency got=%0d exp=2", lat); end
        checks++; if (s_if.out_sum !== 8'h00) begin errors++; $display("FAIL cc_sum got=%h exp=00", s_if.out_sum); end
        checks++; if (s_if.out_cout !== 1'b1) begin errors++; $display("FAIL cc_cout got=%b exp=1", s_if.out_cout); end
        $display("op FF+01+0: sum=%h cout=%b lat=%0d", s_if.out_sum, s_if.out_cout, lat);
        pop8();
        checks++; if (s_if.out_val !== 1'b0) begin errors++; $display("FAIL cc_pop_val got=%b exp=0", s_if.out_val); end
    endtask

    task automatic test_handshake();
        int lat;
        checks++; if (s_if.in_rdy !== 1'b1) begin errors++; $display("FAIL hs_pre_rdy got=%b exp=1", s_if.in_rdy); end
        issue8(8'h12, 8'h34, 1'b1);
        lat = 0;
        while (s_if.out_val !== 1'b1 && lat < 20) begin
            checks++; if (s_if.in_rdy !== 1'b0) begin errors++; $display("FAIL hs_calc_rdy got=%b exp=0 cyc=%0d", s_if.in_rdy, lat); end
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 2) begin errors++; $display("FAIL hs_latency got=%0d exp=2", lat); end
        checks++; if (s_if.in_rdy !== 1'b0) begin errors++; $display("FAIL hs_done_rdy got=%b exp=0", s_if.in_rdy); end
        checks++; if (s_if.out_sum !== 8'h47) begin errors++; $display("FAIL hs_sum got=%h exp=47", s_if.out_sum); end
        checks++; if (s_if.out_cout !== 1'b0) begin errors++; $display("FAIL hs_cout got=%b exp=0", s_if.out_cout); end
        $display("op 12+34+1: sum=%h cout=%b lat=%0d", s_if.out_sum, s_if.out_cout, lat);
        pop8();
        checks++; if (s_if.in_rdy !== 1'b1) begin errors++; $display("FAIL hs_post_rdy got=%b exp=1", s_if.in_rdy); end
        checks++; if (s_if.out_val !== 1'b0) begin errors++; $display("FAIL hs_post_val got=%b exp=0", s_if.out_val); end
    endtask

    task automatic test_stall();
        int lat;
        issue8(8'hC3, 8'h5A, 1'b0);
        wait_val8(lat);
        checks++; if (s_if.out_sum !== 8'h1D) begin errors++; $display("FAIL st_sum got=%h exp=1D", s_if.out_sum); end
        checks++; if (s_if.out_cout !== 1'b1) begin errors++; $display("FAIL st_cout got=%b exp=1", s_if.out_cout); end
        $display("op C3+5A+0: sum=%h cout=%b lat=%0d", s_if.out_sum, s_if.out_cout, lat);
        // New operands offered while the result is stalled must be ignored.
        s_if.in_val  = 1'b1;
        s_if.in_a    = 8'h01;
        s_if.in_b    = 8'h01;
        s_if.in_cin  = 1'b0;
        s_if.out_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (s_if.out_val !== 1'b1) begin errors++; $display("FAIL st_hold_val got=%b exp=1 cyc=%0d", s_if.out_val, c); end
            checks++; if (s_if.out_sum !== 8'h1D) begin errors++; $display("FAIL st_hold_sum got=%h exp=1D cyc=%0d", s_if.out_sum, c); end
            checks++; if (s_if.out_cout !== 1'b1) begin errors++; $display("FAIL st_hold_cout got=%b exp=1 cyc=%0d", s_if.out_cout, c); end
            checks++; if (s_if.in_rdy !== 1'b0) begin errors++; $display("FAIL st_hold_rdy got=%b exp=0 cyc=%0d", s_if.in_rdy, c); end
        end
        s_if.in_val = 1'b0;
        pop8();
        checks++; if (s_if.out_val !== 1'b0) begin errors++; $display("FAIL st_pop_val got=%b exp=0", s_if.out_val); end
        checks++; if (s_if.in_rdy !== 1'b1) begin errors++; $display("FAIL st_pop_rdy got=%b exp=1", s_if.in_rdy); end
        checks++; if (s_if.out_sum !== 8'h1D) begin errors++; $display("FAIL st_retain_sum got=%h exp=1D", s_if.out_sum); end
        @(negedge clk);
        checks++; if (s_if.in_rdy !== 1'b1) begin errors++; $display("FAIL st_idle_rdy got=%b exp=1", s_if.in_rdy); end
        $display("stall: held 5 cycles, sum retained=%h", s_if.out_sum);
    endtask

    task automatic test_reset_abort();
        int lat;
        issue8(8'hAA, 8'h55, 1'b0);
        reset_n = 1'b0;
        #1;
        checks++; if (s_if.out_val !== 1'b0) begin errors++; $display("FAIL ab_val got=%b exp=0", s_if.out_val); end
        checks++; if (s_if.out_sum !== 8'h00) begin errors++; $display("FAIL ab_sum got=%h exp=00", s_if.out_sum); end
        checks++; if (s_if.out_cout !== 1'b0) begin errors++; $display("FAIL ab_cout got=%b exp=0", s_if.out_cout); end
        checks++; if (s_if.in_rdy !== 1'b1) begin errors++; $display("FAIL ab_rdy got=%b exp=1", s_if.in_rdy); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (s_if.out_val !== 1'b0) begin errors++; $display("FAIL ab_no_pulse got=%b exp=0 cyc=%0d", s_if.out_val, c); end
        end
        issue8(8'h0A, 8'h05, 1'b0);
        wait_val8(lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL ab_latency got=%0d exp=2", lat); end
        checks++; if (s_if.out_sum !== 8'h0F) begin errors++; $display("FAIL ab_sum2 got=%h exp=0F", s_if.out_sum); end
        checks++; if (s_if.out_cout !== 1'b0) begin errors++; $display("FAIL ab_cout2 got=%b exp=0", s_if.out_cout); end
        $display("op 0A+05+0 after abort: sum=%h cout=%b lat=%0d", s_if.out_sum, s_if.out_cout, lat);
        pop8();
    endtask

`ifdef CHUNKED_ADDER_OVERFLOW_EN
    task automatic test_overflow();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [7:0] vs [3];
        logic       vc [3];
        logic       vo [3];
        int lat;
        va[0] = 8'h7F; vb[0] = 8'h01; vs[0] = 8'h80; vc[0] = 1'b0; vo[0] = 1'b1;
        va[1] = 8'h80; vb[1] = 8'h80; vs[1] = 8'h00; vc[1] = 1'b1; vo[1] = 1'b1;
        va[2] = 8'h10; vb[2] = 8'h20; vs[2] = 8'h30; vc[2] = 1'b0; vo[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue8(va[i], vb[i], 1'b0);
            wait_val8(lat);
            checks++; if (s_if.out_sum !== vs[i]) begin errors++; $display("FAIL ovf_sum%0d got=%h exp=%h", i, s_if.out_sum, vs[i]); end
            checks++; if (s_if.out_cout !== vc[i]) begin errors++; $display("FAIL ovf_cout%0d got=%b exp=%b", i, s_if.out_cout, vc[i]); end
            checks++; if (s_if.out_ovf !== vo[i]) begin errors++; $display("FAIL ovf_flag%0d got=%b exp=%b", i, s_if.out_ovf, vo[i]); end
            $display("op %h+%h+0: sum=%h cout=%b ovf=%b", va[i], vb[i], s_if.out_sum, s_if.out_cout, s_if.out_ovf);
            pop8();
        end
    endtask
`endif

    task automatic test_back_to_back(input int k, input int nchunks);
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [32:0] exp_full;
        logic        rdy;
        int          lat;
        int          st;
        for (int n = 0; n < 1000; n++) begin
            checks++; if (rv_in_rdy[k] !== 1'b1) begin errors++; $display("FAIL b2b%0d_rdy op=%0d got=%b exp=1", nchunks, n, rv_in_rdy[k]); end
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom_range(0, 1));
            exp_full = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            rv_in_a[k]   = a;
            rv_in_b[k]   = b;
            rv_in_cin[k] = cin;
            rv_in_val[k] = 1'b1;
            @(negedge clk);
            rv_in_val[k] = 1'b0;
            lat = 0;
            while (rv_out_val[k] !== 1'b1 && lat < nchunks + 10) begin
                @(negedge clk);
                lat++;
            end
            checks++; if (lat !== nchunks) begin errors++; $display("FAIL b2b%0d_latency op=%0d got=%0d exp=%0d", nchunks, n, lat, nchunks); end
            checks++;
            if ({rv_out_cout[k], rv_out_sum[k]} !== exp_full) begin
                errors++;
                $display("FAIL b2b%0d_sum op=%0d a=%h b=%h cin=%b got=%b_%h exp=%b_%h", nchunks, n, a, b, cin,
                         rv_out_cout[k], rv_out_sum[k], exp_full[32], exp_full[31:0]);
            end
            $display("b2b n=%0d op=%0d %h+%h+%b sum=%h cout=%b lat=%0d", nchunks, n, a, b, cin, rv_out_sum[k], rv_out_cout[k], lat);
            st = 0;
            do begin
                rdy = (st >= 8) ? 1'b1 : ($urandom_range(0, 3) != 0);
                rv_out_rdy[k] = rdy;
                @(negedge clk);
                st++;
            end while (!rdy);
            rv_out_rdy[k] = 1'b0;
        end
    endtask

    // Watchdog so a stuck design still ends the run.
    initial begin
        #5_000_000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        errors       = 0;
        checks       = 0;
        reset_n      = 1'b0;
        s_if.in_val  = 1'b0;
        s_if.in_a    = 8'h00;
        s_if.in_b    = 8'h00;
        s_if.in_cin  = 1'b0;
        s_if.out_rdy = 1'b0;
        rv_in_val    = '0;
        rv_in_a      = '0;
        rv_in_b      = '0;
        rv_in_cin    = '0;
        rv_out_rdy   = '0;
        test_reset();
        test_carry_chain();
        test_handshake();
        test_stall();
        test_reset_abort();
`ifdef CHUNKED_ADDER_OVERFLOW_EN
        test_overflow();
`endif
        test_back_to_back(0, 32);
        test_back_to_back(1, 8);
        test_back_to_back(2, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chunked_adder.md
CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 SHALL have parameter NBITS, default 32: operand and sum width.
REQ-002 SHALL have parameter CBITS, default 4: bits added per cycle; NBITS SHALL be an integer multiple of CBITS, and NCHUNKS = NBITS/CBITS.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port in_val, input, 1: operands valid.
REQ-006 SHALL have port in_rdy, output, 1: block can accept operands.
REQ-007 SHALL have port in_a, input, NBITS: operand A.
REQ-008 SHALL have port in_b, input, NBITS: operand B.
REQ-009 SHALL have port in_cin, input, 1: carry-in.
REQ-010 SHALL have port out_val, output, 1: result valid.
REQ-011 SHALL have port out_rdy, input, 1: consumer accepts the result.
REQ-012 SHALL have port out_sum, output, NBITS: sum.
REQ-013 SHALL have port out_cout, output, 1: carry-out of the MSB.

Function
REQ-014 SHALL implement FSM states IDLE, CALC and DONE; in_rdy is 1 only in IDLE, and out_val is 1 only in DONE.
REQ-015 IDLE: on a rising edge with in_val=1, SHALL latch in_a, in_b and in_cin (carry register = in_cin), set chunk index to 0 and go to CALC; otherwise SHALL stay in IDLE.
REQ-016 CALC: each edge SHALL compute {c, s} = a[idx] + b[idx] + carry on CBITS-bit chunk idx, write s into sum register chunk idx, set carry = c and increment idx.
REQ-017 CALC: the edge that processes chunk NCHUNKS-1 SHALL move to DONE; NBITS == CBITS therefore gives exactly one CALC cycle.
REQ-018 Latency: out_val SHALL rise exactly NCHUNKS cycles after the accepting edge.
REQ-019 Minimum issue interval SHALL be NCHUNKS+2 cycles (accept, NCHUNKS CALC cycles, pop, back in IDLE).
REQ-020 DONE: out_sum and out_cout SHALL hold stable while out_val=1 and out_rdy=0; a rising edge with out_rdy=1 SHALL move to IDLE.
REQ-021 in_val SHALL be ignored in CALC and DONE; the latched operands SHALL NOT change after acceptance.
REQ-022 After a pop, out_sum and out_cout SHALL retain the last result until the next result is written.
REQ-023 Arithmetic SHALL be modulo 2^NBITS, with out_cout equal to bit NBITS of in_a + in_b + in_cin.

Reset
REQ-024 When reset_n=0, the block SHALL immediately (asynchronously) set state=IDLE, out_val=0, out_sum=0, out_cout=0, carry=0 and idx=0.
REQ-025 in_rdy SHALL read 1 while in reset and after reset release.
REQ-026 Reset asserted during CALC or DONE SHALL abort and discard the operation, with no output pulse.

Configuration
REQ-027 With macro CHUNKED_ADDER_OVERFLOW_EN defined, SHALL add port out_ovf, output, 1: two's-complement signed overflow, equal to the carry into the MSB XOR out_cout.
REQ-028 out_ovf SHALL follow the same valid, hold and reset (0) rules as out_cout.
REQ-029 Without CHUNKED_ADDER_OVERFLOW_EN, out_ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (NBITS=8, CBITS=4 unless stated)
REQ-030 Accept in_a=0xFF, in_b=0x01, in_cin=0 -> out_val rises 2 cycles after acceptance with out_sum=0x00, out_cout=1.
REQ-031 in_a=0x12, in_b=0x34, in_cin=1 -> out_sum=0x47, out_cout=0; in_rdy=0 from acceptance until the cycle after the pop.
REQ-032 Hold out_rdy=0 for 5 cycles in DONE while in_val=1 -> out_sum/out_cout stable, in_rdy=0, no new operands accepted; out_rdy=1 -> IDLE next cycle.
REQ-033 Assert reset_n=0 in the first CALC cycle -> out_val=0 and out_sum=0 immediately; after release, 0x0A+0x05 gives 0x0F.
REQ-034 With CHUNKED_ADDER_OVERFLOW_EN: 0x7F+0x01 -> sum 0x80, ovf=1, cout=0; 0x80+0x80 -> sum 0x00, cout=1, ovf=1; 0x10+0x20 -> ovf=0.
REQ-035 Run 1000 random back-to-back ops at NBITS=32 with CBITS=1, 4 and 32 against a+b+cin, with random out_rdy stalls -> all results match and latency equals NCHUNKS.
